// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the sequence detector.
// A one-word holding buffer lets back-to-back words stream out gap-free.
module seq_serializer #(
    parameter int   DATA_W    = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0,
    parameter int   CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              pause,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              word_done,
    output logic              busy,
    output logic [CNT_W-1:0]  words_sent
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] hold;
    logic              hold_full;
    logic              hold_clr;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] sr_n;
    logic [DATA_W-1:0] sr_sh;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic              done_n;
    logic              take;

    // Ready only depends on the buffer flag, never on in_valid.
    assign in_ready = !hold_full && !reset;
    assign take     = in_valid && in_ready;

    assign sr_sh = MSB_FIRST ? {sr[DATA_W-2:0], 1'b0}
                             : {1'b0, sr[DATA_W-1:1]};

    always_comb begin
        state_n  = state;
        sr_n     = sr;
        cnt_n    = cnt;
        hold_clr = 1'b0;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (hold_full) begin
                    sr_n     = hold;
                    hold_clr = 1'b1;
                    cnt_n    = '0;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (!pause) begin
                    if (cnt == LAST) begin
                        done_n = 1'b1;
                        // Reload straight from the buffer: no idle bit between words.
                        if (hold_full) begin
                            sr_n     = hold;
                            hold_clr = 1'b1;
                            cnt_n    = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        sr_n  = sr_sh;
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            word_done  <= 1'b0;
            words_sent <= '0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            cnt       <= cnt_n;
            word_done <= done_n;
            if (take) begin
                hold      <= in_data;
                hold_full <= 1'b1;
            end else if (hold_clr) begin
                hold_full <= 1'b0;
            end
            if (done_n) begin
                words_sent <= words_sent + CNT_W'(1);
            end
        end
    end

    always_comb begin
        ser_out   = IDLE_BIT;
        ser_valid = 1'b0;
        if (state == SHIFT) begin
            ser_out   = MSB_FIRST ? sr[DATA_W-1] : sr[0];
            ser_valid = !pause;
        end
    end

    assign busy = (state == SHIFT) || hold_full;

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench for seq_serializer: MSB-first/16-bit counter instance
// and an LSB-first/4-bit counter instance.
module tb_seq_serializer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [7:0]  a_data;
    logic        a_valid, a_ready, a_pause, a_ser, a_sv, a_wd, a_busy;
    logic [15:0] a_ws;
    logic [7:0]  b_data;
    logic        b_valid, b_ready, b_pause, b_ser, b_sv, b_wd, b_busy;
    logic [3:0]  b_ws;

    seq_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(16)) u_a (
        .clock(clock), .reset(reset), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .pause(a_pause), .ser_out(a_ser), .ser_valid(a_sv),
        .word_done(a_wd), .busy(a_busy), .words_sent(a_ws)
    );

    seq_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(4)) u_b (
        .clock(clock), .reset(reset), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .pause(b_pause), .ser_out(b_ser), .ser_valid(b_sv),
        .word_done(b_wd), .busy(b_busy), .words_sent(b_ws)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    bit qa[$];
    bit qb[$];
    int wd_t[$];
    int a_wd_n = 0, b_wd_n = 0, a_bits = 0, cyc = 0, run_a = 0, max_run_a = 0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (!reset) begin
            if (a_sv) begin
                a_bits++;
                run_a++;
                if (run_a > max_run_a) max_run_a = run_a;
                if (qa.size() == 0) check("a_extra_bit", 1, 0);
                else check("a_bit", a_ser, qa.pop_front());
            end else begin
                run_a = 0;
            end
            if (a_wd) begin
                a_wd_n++;
                wd_t.push_back(cyc);
            end
            if (b_sv) begin
                if (qb.size() == 0) check("b_extra_bit", 1, 0);
                else check("b_bit", b_ser, qb.pop_front());
            end
            if (b_wd) b_wd_n++;
        end
    end

    task automatic send_a(input logic [7:0] d);
        int n = 0;
        a_data  = d;
        a_valid = 1'b1;
        while (!a_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("a_send_ready", a_ready, 1);
        if (a_ready) for (int i = 7; i >= 0; i--) qa.push_back(d[i]);
        @(negedge clock);
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        int n = 0;
        b_data  = d;
        b_valid = 1'b1;
        while (!b_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("b_send_ready", b_ready, 1);
        if (b_ready) for (int i = 0; i < 8; i++) qb.push_back(d[i]);
        @(negedge clock);
        b_valid = 1'b0;
    endtask

    task automatic wait_a();
        int n = 0;
        while ((qa.size() != 0 || a_busy) && n < 300) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        check("a_drained", qa.size(), 0);
    endtask

    task automatic wait_b();
        int n = 0;
        while ((qb.size() != 0 || b_busy) && n < 300) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        check("b_drained", qb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, wd0, n, gap;
        a_data = '0; a_valid = 1'b0; a_pause = 1'b0;
        b_data = '0; b_valid = 1'b0; b_pause = 1'b0;
        #1;
        check("rst_ready", a_ready, 0);
        check("rst_sv", a_sv, 0);
        check("rst_ser", a_ser, 0);
        check("rst_busy", a_busy, 0);
        check("rst_ws", a_ws, 0);
        check("rst_wd", a_wd, 0);
        check("rst_b_ws", b_ws, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_ready", a_ready, 1);
        @(negedge clock);

        // single word
        send_a(8'hB4);
        wait_a();
        check("t1_ws", a_ws, 1);
        check("t1_wd", a_wd_n, 1);
        check("t1_run", max_run_a, 8);

        // back-to-back words, valid held
        max_run_a = 0;
        wd_t.delete();
        send_a(8'hB4);
        send_a(8'h0F);
        check("t2_ready_full", a_ready, 0);
        check("t2_busy", a_busy, 1);
        wait_a();
        check("t2_ws", a_ws, 3);
        check("t2_wd", a_wd_n, 3);
        check("t2_run", max_run_a, 16);
        check("t2_wd_n", wd_t.size(), 2);
        gap = (wd_t.size() >= 2) ? wd_t[1] - wd_t[0] : -1;
        check("t2_wd_gap", gap, 8);

        // pause for 3 cycles after bit 3
        base = a_bits;
        send_a(8'hA5);
        n = 0;
        while (a_bits < base + 3 && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("t3_bits3", a_bits - base, 3);
        @(posedge clock);
        #1 a_pause = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("t3_pause_sv", a_sv, 0);
            check("t3_pause_busy", a_busy, 1);
        end
        @(posedge clock);
        #1 a_pause = 1'b0;
        wait_a();
        check("t3_bits", a_bits - base, 8);
        check("t3_ws", a_ws, 4);

        // asynchronous reset mid-word with a buffered word
        base = a_bits;
        wd0 = a_wd_n;
        send_a(8'hFF);
        send_a(8'hFF);
        n = 0;
        while (a_bits < base + 5 && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("t4_ser", a_ser, 0);
        check("t4_sv", a_sv, 0);
        check("t4_busy", a_busy, 0);
        check("t4_ws", a_ws, 0);
        check("t4_ready", a_ready, 0);
        check("t4_wd", a_wd, 0);
        qa.delete();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t4_no_wd", a_wd_n, wd0);
        send_a(8'h3C);
        wait_a();
        check("t4_post_ws", a_ws, 1);
        check("t4_post_wd", a_wd_n, wd0 + 1);

        // pause while idle: load still happens, bit held invalid
        a_pause = 1'b1;
        send_a(8'h81);
        repeat (3) @(negedge clock);
        check("t5_sv", a_sv, 0);
        check("t5_busy", a_busy, 1);
        check("t5_ser", a_ser, 1);
        check("t5_ready", a_ready, 1);
        a_pause = 1'b0;
        wait_a();
        check("t5_ws", a_ws, 2);

        // LSB first, then counter wrap at 4 bits
        send_b(8'h01);
        wait_b();
        check("t6_ws", b_ws, 1);
        for (int i = 0; i < 16; i++) send_b(8'($urandom));
        wait_b();
        check("t7_ws_wrap", b_ws, 1);
        check("t7_wd", b_wd_n, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
